// File: rtl/instr_encode_rv.sv
// ============================================================================
//  Module   : instr_encode_rv
//  Brief    : Field-level RV32I instruction encoder. Accepts one request per
//             cycle, checks it for legality, packs legal requests into a
//             32-bit word and queues {word, address} in a 2-entry FIFO.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_encode_rv #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter int                ERR_W      = 8
) (
  input  logic              iwClk,
  input  logic              iwRst,
  input  logic              iwReqValid,
  output logic              owReqReady,
  input  logic [3:0]        iwReqClass,
  input  logic [2:0]        iwFunct3,
  input  logic              iwAlt,
  input  logic [4:0]        iwRd,
  input  logic [4:0]        iwRs1,
  input  logic [4:0]        iwRs2,
  input  logic [31:0]       iwImm,
  input  logic              iwSetBase,
  input  logic [ADDR_W-1:0] iwBase,
  output logic              owInstrValid,
  input  logic              iwInstrReady,
  output logic [31:0]       owInstr,
  output logic [ADDR_W-1:0] owInstrAddr,
  output logic              owErr,
  output logic [ERR_W-1:0]  owErrCount
);

  localparam logic [3:0] CLS_LUI    = 4'd0;
  localparam logic [3:0] CLS_AUIPC  = 4'd1;
  localparam logic [3:0] CLS_JAL    = 4'd2;
  localparam logic [3:0] CLS_JALR   = 4'd3;
  localparam logic [3:0] CLS_BRANCH = 4'd4;
  localparam logic [3:0] CLS_LOAD   = 4'd5;
  localparam logic [3:0] CLS_STORE  = 4'd6;
  localparam logic [3:0] CLS_OP_IMM = 4'd7;
  localparam logic [3:0] CLS_OP     = 4'd8;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Two-slot FIFO: slot 0 is always the head.
  logic [1:0]        count;
  logic [31:0]       word0, word1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [ADDR_W-1:0] addr_cnt;
  logic              err_pulse;
  logic [ERR_W-1:0]  err_cnt;

  logic              legal;
  logic [31:0]       enc;
  logic              accept, push, pop;
  logic [ADDR_W-1:0] tag;

  // A value fits an N-bit signed field when all bits from N-1 upward agree.
  logic fits12, fits13, fits21, is_shift;
  logic [11:0] i_imm;

  assign fits12   = (&iwImm[31:11]) | ~(|iwImm[31:11]);
  assign fits13   = (&iwImm[31:12]) | ~(|iwImm[31:12]);
  assign fits21   = (&iwImm[31:20]) | ~(|iwImm[31:20]);
  assign is_shift = (iwFunct3 == 3'd1) | (iwFunct3 == 3'd5);
  // Shift-immediates carry funct7 (with the SRAI alt bit) above a 5-bit shamt.
  assign i_imm    = ((iwReqClass == CLS_OP_IMM) && is_shift) ?
                    {1'b0, iwAlt, 5'b0, iwImm[4:0]} : iwImm[11:0];

  // Ready depends only on the registered occupancy.
  assign owReqReady = (count != 2'd2);
  assign accept     = iwReqValid & owReqReady;
  assign push       = accept & legal;
  assign pop        = (count != 2'd0) & iwInstrReady;
  // A base load in the same cycle retags the accepted request.
  assign tag        = iwSetBase ? iwBase : addr_cnt;

  // Legality of the presented request.
  always_comb begin
    legal = 1'b0;
    case (iwReqClass)
      CLS_LUI, CLS_AUIPC: legal = (iwImm[11:0] == 12'd0) & ~iwAlt;
      CLS_JAL:    legal = fits21 & ~iwImm[0] & ~iwAlt;
      CLS_JALR:   legal = (iwFunct3 == 3'd0) & fits12 & ~iwAlt;
      CLS_BRANCH: legal = (iwFunct3 != 3'd2) & (iwFunct3 != 3'd3) &
                          fits13 & ~iwImm[0] & ~iwAlt;
      CLS_LOAD:   legal = (iwFunct3 != 3'd3) & (iwFunct3 != 3'd6) &
                          (iwFunct3 != 3'd7) & fits12 & ~iwAlt;
      CLS_STORE:  legal = (iwFunct3 <= 3'd2) & fits12 & ~iwAlt;
      CLS_OP_IMM: begin
        if (is_shift) legal = (iwImm[31:5] == 27'd0) & (~iwAlt | (iwFunct3 == 3'd5));
        else          legal = fits12 & ~iwAlt;
      end
      CLS_OP:     legal = ~iwAlt | (iwFunct3 == 3'd0) | (iwFunct3 == 3'd5);
      default:    legal = 1'b0;
    endcase
  end

  // Pack fields into the standard R/I/S/B/U/J layouts.
  always_comb begin
    enc = 32'd0;
    case (iwReqClass)
      CLS_LUI:    enc = {iwImm[31:12], iwRd, OPC_LUI};
      CLS_AUIPC:  enc = {iwImm[31:12], iwRd, OPC_AUIPC};
      CLS_JAL:    enc = {iwImm[20], iwImm[10:1], iwImm[11], iwImm[19:12], iwRd, OPC_JAL};
      CLS_JALR:   enc = {i_imm, iwRs1, iwFunct3, iwRd, OPC_JALR};
      CLS_BRANCH: enc = {iwImm[12], iwImm[10:5], iwRs2, iwRs1, iwFunct3,
                         iwImm[4:1], iwImm[11], OPC_BRANCH};
      CLS_LOAD:   enc = {i_imm, iwRs1, iwFunct3, iwRd, OPC_LOAD};
      CLS_STORE:  enc = {iwImm[11:5], iwRs2, iwRs1, iwFunct3, iwImm[4:0], OPC_STORE};
      CLS_OP_IMM: enc = {i_imm, iwRs1, iwFunct3, iwRd, OPC_OP_IMM};
      CLS_OP:     enc = {1'b0, iwAlt, 5'b0, iwRs2, iwRs1, iwFunct3, iwRd, OPC_OP};
      default:    enc = 32'd0;
    endcase
  end

  // FIFO storage and occupancy; slot 1 shifts into slot 0 on pop.
  always_ff @(posedge iwClk) begin
    if (iwRst) begin
      count <= 2'd0;
      word0 <= 32'd0;
      word1 <= 32'd0;
      addr0 <= '0;
      addr1 <= '0;
    end else begin
      if (pop && push) begin
        if (count == 2'd1) begin
          word0 <= enc;
          addr0 <= tag;
        end else begin
          word0 <= word1;
          addr0 <= addr1;
          word1 <= enc;
          addr1 <= tag;
        end
      end else if (pop) begin
        word0 <= word1;
        addr0 <= addr1;
        count <= count - 2'd1;
      end else if (push) begin
        if (count == 2'd0) begin
          word0 <= enc;
          addr0 <= tag;
        end else begin
          word1 <= enc;
          addr1 <= tag;
        end
        count <= count + 2'd1;
      end
    end
  end

  // Instruction address counter; advances by one word per legal accept.
  always_ff @(posedge iwClk) begin
    if (iwRst)          addr_cnt <= RESET_ADDR;
    else if (iwSetBase) addr_cnt <= iwBase + (push ? ADDR_W'(4) : ADDR_W'(0));
    else if (push)      addr_cnt <= addr_cnt + ADDR_W'(4);
  end

  // Error pulse and saturating dropped-request counter.
  always_ff @(posedge iwClk) begin
    if (iwRst) begin
      err_pulse <= 1'b0;
      err_cnt   <= '0;
    end else begin
      err_pulse <= accept & ~legal;
      if (accept && !legal && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
    end
  end

  assign owInstrValid = (count != 2'd0);
  assign owInstr      = word0;
  assign owInstrAddr  = addr0;
  assign owErr        = err_pulse;
  assign owErrCount   = err_cnt;

endmodule

`default_nettype wire
